// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns an ALU byte address into one word-wide memory access
// with lane alignment, store masks, load extension, and misalignment/illegal/timeout errors.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           load_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;

  state_t          state;
  logic [2:0]      funct3_q;
  logic [1:0]      offset_q;
  logic            is_load_q;
  logic [CntW-1:0] tcnt;

  logic        op_legal;
  logic        op_misaligned;
  logic [1:0]  off;
  logic [31:0] wdata_lane;
  logic [3:0]  wmask_lane;
  logic [31:0] rdata_shifted;
  logic [31:0] rdata_fmt;
  logic        timeout_hit;

  // Decode of the op presented at start; only consulted in StIdle.
  always_comb begin
    off      = addr[1:0];
    op_legal = 1'b0;
    if (mem_read && !mem_write) begin
      op_legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end else if (mem_write && !mem_read) begin
      op_legal = funct3 inside {3'b000, 3'b001, 3'b010};
    end

    op_misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   op_misaligned = off[0];
      2'b10:   op_misaligned = (off != 2'b00);
      default: op_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    wdata_lane = store_data;
    wmask_lane = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        wdata_lane = {4{store_data[7:0]}};
        wmask_lane = 4'b0001 << off;
      end
      2'b01: begin
        wdata_lane = {2{store_data[15:0]}};
        wmask_lane = 4'b0011 << off;
      end
      default: begin
        wdata_lane = store_data;
        wmask_lane = 4'b1111;
      end
    endcase
    if (!mem_write) begin
      wmask_lane = 4'b0000;
    end
  end

  always_comb begin
    rdata_shifted = mem_rdata >> {offset_q, 3'b000};
    case (funct3_q)
      3'b000:  rdata_fmt = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  rdata_fmt = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  rdata_fmt = {24'h000000, rdata_shifted[7:0]};
      3'b101:  rdata_fmt = {16'h0000, rdata_shifted[15:0]};
      default: rdata_fmt = rdata_shifted;
    endcase
  end

  // Expiry is flagged on the cycle whose miss would bring the count to TIMEOUT_CYCLES.
  always_comb begin
    timeout_hit = 1'b0;
    if (TIMEOUT_CYCLES != 0) begin
      timeout_hit = (({{(32 - CntW){1'b0}}, tcnt} + 32'd1) == TIMEOUT_CYCLES);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      load_data <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      funct3_q  <= '0;
      offset_q  <= '0;
      is_load_q <= 1'b0;
      tcnt      <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            busy <= 1'b1;
            if (op_legal && !op_misaligned) begin
              state     <= StAccess;
              mem_req   <= 1'b1;
              mem_we    <= mem_write;
              mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata <= wdata_lane;
              mem_wmask <= wmask_lane;
              funct3_q  <= funct3;
              offset_q  <= off;
              is_load_q <= mem_read;
              tcnt      <= '0;
            end else begin
              state     <= StDone;
              done      <= 1'b1;
              err       <= 1'b1;
              load_data <= '0;
            end
          end
        end

        StAccess: begin
          if (mem_ready) begin
            state     <= StDone;
            done      <= 1'b1;
            err       <= 1'b0;
            load_data <= is_load_q ? rdata_fmt : 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wmask <= '0;
          end else if (timeout_hit) begin
            state     <= StDone;
            done      <= 1'b1;
            err       <= 1'b1;
            load_data <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wmask <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        StDone: begin
          state     <= StIdle;
          busy      <= 1'b0;
          done      <= 1'b0;
          err       <= 1'b0;
          load_data <= '0;
        end

        default: begin
          state   <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
          err     <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected results are queued at issue and checked at done.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;

  load_store_unit #(
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .store_data(store_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .load_data (load_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd);
    start      = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    step();
    start = 1'b0;
  endtask

  // Wait (bounded) for done, then compare against the oldest queued expectation.
  task automatic wait_done(input string tag);
    exp_t e;
    int   n = 0;
    while (!done && n < 10) begin
      step();
      n++;
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_sb_size"}, sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_load_data"}, load_data, e.data);
      check({tag, "_err"}, err, e.err);
    end
    step();
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic do_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                       input int delay, input logic legal, input logic [31:0] exp_addr,
                       input logic [31:0] exp_wdata, input logic [3:0] exp_wmask,
                       input logic [31:0] exp_data);
    exp_t e;
    e.data = exp_data;
    e.err  = !legal;
    sb.push_back(e);
    drive_start(rd, wr, f3, a, sd);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_req"}, mem_req, legal);
    if (legal) begin
      check({tag, "_addr"}, mem_addr, exp_addr);
      check({tag, "_we"}, mem_we, wr);
      check({tag, "_wmask"}, mem_wmask, exp_wmask);
      if (wr) check({tag, "_wdata"}, mem_wdata, exp_wdata);
      for (int i = 0; i < delay; i++) begin
        mem_ready = 1'b0;
        step();
        check({tag, "_req_hold"}, mem_req, 1'b1);
        check({tag, "_addr_hold"}, mem_addr, exp_addr);
      end
      mem_ready = 1'b1;
      mem_rdata = rdata;
      step();
      mem_ready = 1'b0;
      check({tag, "_req_drop"}, mem_req, 1'b0);
    end
    wait_done(tag);
  endtask

  initial begin
    int n;
    int req_rises;
    logic seen_done;
    logic prev_req;
    exp_t e;

    reset      = 1'b1;
    start      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'b000;
    addr       = '0;
    store_data = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    step();
    step();
    reset = 1'b0;
    step();

    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_req", mem_req, 1'b0);
    check("rst_wmask", mem_wmask, 4'h0);

    // Loads
    do_op("lw", 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 32'h100, 32'h0, 4'b0000,
          32'hDEADBEEF);
    do_op("lb", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 1, 32'h100, 32'h0, 4'b0000,
          32'hFFFFFF80);
    do_op("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0, 1, 32'h100, 32'h0, 4'b0000,
          32'h00000080);
    do_op("lh", 1, 0, 3'b001, 32'h102, 32'h0, 32'h80123456, 2, 1, 32'h100, 32'h0, 4'b0000,
          32'hFFFF8012);
    do_op("lhu", 1, 0, 3'b101, 32'h102, 32'h0, 32'h80123456, 0, 1, 32'h100, 32'h0, 4'b0000,
          32'h00008012);
    do_op("lb1", 1, 0, 3'b000, 32'h201, 32'h0, 32'h11227F44, 0, 1, 32'h200, 32'h0, 4'b0000,
          32'h0000007F);

    // Stores
    do_op("sh", 0, 1, 3'b001, 32'h102, 32'h1234BEEF, 32'hFFFFFFFF, 1, 1, 32'h100, 32'hBEEFBEEF,
          4'b1100, 32'h0);
    do_op("sb", 0, 1, 3'b000, 32'h101, 32'h000000AB, 32'h0, 0, 1, 32'h100, 32'hABABABAB,
          4'b0010, 32'h0);
    do_op("sw", 0, 1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0, 0, 1, 32'h104, 32'hCAFEF00D,
          4'b1111, 32'h0);

    // Error path: no request, done+err in the cycle after start
    do_op("lw_mis", 1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    do_op("rw_both", 1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    do_op("rw_none", 0, 0, 3'b010, 32'h100, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    do_op("ld_f3", 1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    do_op("st_f3", 0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    do_op("sh_mis", 0, 1, 3'b001, 32'h103, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);

    // Timeout with mem_ready never asserted: request lasts exactly 4 cycles
    e.data = 32'h0;
    e.err  = 1'b1;
    sb.push_back(e);
    drive_start(1, 0, 3'b010, 32'h200, 32'h0);
    n = 0;
    while (mem_req && n < 10) begin
      n++;
      step();
    end
    check("to_req_cycles", n, 4);
    wait_done("to");

    // mem_ready arriving on the expiry cycle wins
    do_op("to_edge", 1, 0, 3'b010, 32'h204, 32'h0, 32'h13579BDF, 3, 1, 32'h204, 32'h0, 4'b0000,
          32'h13579BDF);

    // Reset during ACCESS: outputs drop before the next edge, no done
    drive_start(1, 0, 3'b010, 32'h300, 32'h0);
    check("rstmid_req_before", mem_req, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("rstmid_req_async", mem_req, 1'b0);
    check("rstmid_busy_async", busy, 1'b0);
    step();
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mem_ready = 1'b1;
      step();
      seen_done = seen_done | done;
    end
    mem_ready = 1'b0;
    check("rstmid_no_done", seen_done, 1'b0);

    // Second start while busy is dropped
    e.data = 32'hA5A5A5A5;
    e.err  = 1'b0;
    sb.push_back(e);
    drive_start(1, 0, 3'b010, 32'h300, 32'h0);
    req_rises = 1;
    prev_req  = mem_req;
    start     = 1'b1;
    addr      = 32'h400;
    step();
    start = 1'b0;
    check("busy_addr_hold", mem_addr, 32'h300);
    mem_ready = 1'b1;
    mem_rdata = 32'hA5A5A5A5;
    step();
    mem_ready = 1'b0;
    wait_done("busy_op");
    for (int i = 0; i < 4; i++) begin
      if (mem_req && !prev_req) req_rises++;
      prev_req = mem_req;
      step();
    end
    check("busy_req_count", req_rises, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
